// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data memory with configurable wait states.
// Accepts byte-enabled word stores and typed loads (LW/LBU/LB/LHU/LH).
// Every access takes WAIT_CYCLES+1 cycles, and stall freezes the pipeline
// until the access reaches its completion cycle.
// Optional feature macro: DM_ALIGN_CHK_EN. When it is defined, the block adds
// an addr_err output and suppresses misaligned accesses.
module dm_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    input  logic [2:0]  ld_op,
    output logic [31:0] rd,
    output logic        stall
`ifdef DM_ALIGN_CHK_EN
    ,
    output logic        addr_err
`endif
);

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic                req;
    logic                complete;
    logic                misaligned;
    logic                ram_we;
    logic [ADDR_W-1:0]   widx;
    logic [31:0]         word;
    logic [31:0]         ld_data;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         mem [2**ADDR_W];

    // The address bits above the RAM index are ignored, so the RAM aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign req  = req_we | req_re;
    assign widx = addr[ADDR_W+1:2];
    assign word = mem[widx];

`ifdef DM_ALIGN_CHK_EN
    // Classify the request as misaligned. Store checks are keyed on the
    // byte-enable pattern. Load checks are keyed on the load type.
    always_comb begin
        misaligned = 1'b0;
        if (req_we) begin
            if (be == 4'b1111)
                misaligned = (addr[1:0] != 2'b00);
            else if (be == 4'b0011 || be == 4'b1100)
                misaligned = addr[0];
        end else if (req_re) begin
            case (ld_op)
                OP_LBU, OP_LB: misaligned = 1'b0;
                OP_LHU, OP_LH: misaligned = addr[0];
                default:       misaligned = (addr[1:0] != 2'b00);
            endcase
        end
    end

    // The error flag is raised only in the request cycle, and is held low during reset.
    assign addr_err = req && (state == IDLE) && misaligned && !rst;
`else
    assign misaligned = 1'b0;
`endif

    // State and wait counter register.
    // NOTE: sequential state uses non-blocking (<=) assignments, so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic, stall generation and detection of the completion cycle.
    // NOTE: every output gets a default at the top of the block, so no latch can be inferred.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stall    = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (req && !misaligned) begin
                    if (WAIT_N == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_n = WAIT;
                        cnt_n   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // The request was withdrawn mid-access, so the access is abandoned without a write.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt < WAIT_N) begin
                    stall = 1'b1;
                    cnt_n = cnt + 4'd1;
                end else begin
                    complete = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Reset kills stall and completion at once, without waiting for a clock edge.
        if (rst) begin
            stall    = 1'b0;
            complete = 1'b0;
        end
    end

    assign ram_we = complete && req_we;

    // Byte-lane RAM write at the closing edge of the completion cycle.
    // NOTE: the RAM array is deliberately left out of reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Lane selection and sign or zero extension of the load data.
    always_comb begin
        byte_sel = word[7:0];
        case (addr[1:0])
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (ld_op)
            OP_LBU:  ld_data = {24'h0, byte_sel};
            OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LHU:  ld_data = {16'h0, half_sel};
            OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            default: ld_data = word;
        endcase
    end

    // Load data is visible only in the completion cycle, and is 0 in every other cycle.
    assign rd = (complete && req_re) ? ld_data : 32'h0;

endmodule
